// File: rtl/stage_ex_pkg.sv
// rtl/stage_ex_pkg.sv - shared aluop/alusel codes, divider states and ALU helpers
package stage_ex_pkg;

  localparam logic [2:0] RES_NOP         = 3'b000;
  localparam logic [2:0] RES_LOGIC       = 3'b001;
  localparam logic [2:0] RES_SHIFT       = 3'b010;
  localparam logic [2:0] RES_MOVE        = 3'b011;
  localparam logic [2:0] RES_ARITH       = 3'b100;
  localparam logic [2:0] RES_MUL         = 3'b101;
  localparam logic [2:0] RES_JUMP_BRANCH = 3'b110;
  localparam logic [2:0] RES_LOAD_STORE  = 3'b111;

  localparam logic [7:0] EXE_NOP_OP   = 8'b00000000;
  localparam logic [7:0] EXE_AND_OP   = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP    = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b00100111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b01111100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b00000010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b00000011;
  localparam logic [7:0] EXE_MOVZ_OP  = 8'b00001010;
  localparam logic [7:0] EXE_MOVN_OP  = 8'b00001011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b00010010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b00101010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b00101011;
  localparam logic [7:0] EXE_ADD_OP   = 8'b00100000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b00100001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b00100010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b00100011;
  localparam logic [7:0] EXE_ADDI_OP  = 8'b01010101;
  localparam logic [7:0] EXE_ADDIU_OP = 8'b01010110;
  localparam logic [7:0] EXE_CLZ_OP   = 8'b10110000;
  localparam logic [7:0] EXE_CLO_OP   = 8'b10110001;
  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_MUL_OP   = 8'b10101001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
  localparam logic [7:0] EXE_JAL_OP   = 8'b01010000;
  localparam logic [7:0] EXE_LW_OP    = 8'b11100011;
  localparam logic [7:0] EXE_SW_OP    = 8'b11101011;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  // Counts leading bits equal to bit_val; an all-matching word yields 32.
  function automatic logic [5:0] count_lead(input logic [31:0] x, input logic bit_val);
    logic done;
    count_lead = '0;
    done = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!done) begin
        if (x[i] == bit_val) count_lead = count_lead + 6'd1;
        else                 done = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/stage_ex_if.sv
// rtl/stage_ex_if.sv - ID/EX operand bus in, EX/MEM result bus out
interface stage_ex_if;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] opv1;
  logic [31:0] opv2;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] link_addr;
  logic [31:0] inst;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        mem_whilo;
  logic        wb_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;

  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        whilo;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [7:0]  aluop_o;
  logic [31:0] mem_addr;
  logic [31:0] store_data;
  logic        stallreq;

  modport master (
    output aluop, alusel, opv1, opv2, we_i, waddr_i, link_addr, inst,
           hi_i, lo_i, mem_whilo, wb_whilo, mem_hi, mem_lo, wb_hi, wb_lo,
    input  we_o, waddr_o, wdata_o, whilo, hi_o, lo_o, aluop_o,
           mem_addr, store_data, stallreq
  );

  modport slave (
    input  aluop, alusel, opv1, opv2, we_i, waddr_i, link_addr, inst,
           hi_i, lo_i, mem_whilo, wb_whilo, mem_hi, mem_lo, wb_hi, wb_lo,
    output we_o, waddr_o, wdata_o, whilo, hi_o, lo_o, aluop_o,
           mem_addr, store_data, stallreq
  );
endinterface

// File: rtl/stage_ex_div.sv
// rtl/stage_ex_div.sv - radix-2 restoring divider, one quotient bit per cycle
module ex_div
  import stage_ex_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic [63:0] result,
  output logic        ready
);

  div_state_e  state, state_nx;
  logic [5:0]  cnt;
  logic [31:0] quo, rem, divisor;
  logic        neg_q, neg_r;
  logic [31:0] abs_a, abs_b;
  logic [32:0] shifted, diff;

  always_comb begin
    abs_a   = (signed_div && opa[31]) ? -opa : opa;
    abs_b   = (signed_div && opb[31]) ? -opb : opb;
    shifted = {rem, quo[31]};
    diff    = shifted - {1'b0, divisor};
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    result   = '0;
    case (state)
      DIV_FREE:   if (start) state_nx = (opb == 32'd0) ? DIV_BYZERO : DIV_ON;
      DIV_BYZERO: state_nx = DIV_END;
      DIV_ON:     if (cnt == 6'(DIV_CYCLES - 1)) state_nx = DIV_END;
      DIV_END: begin
        state_nx = DIV_FREE;
        ready    = 1'b1;
        result   = {(neg_r ? -rem : rem), (neg_q ? -quo : quo)};
      end
      default:    state_nx = DIV_FREE;
    endcase
  end

  // The quotient register doubles as the dividend shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DIV_FREE;
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        DIV_FREE: if (start) begin
          cnt     <= '0;
          quo     <= abs_a;
          rem     <= '0;
          divisor <= abs_b;
          neg_q   <= signed_div & (opa[31] ^ opb[31]);
          neg_r   <= signed_div & opa[31];
        end
        DIV_BYZERO: begin
          quo   <= '0;
          rem   <= '0;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end
        DIV_ON: begin
          if (diff[32]) begin
            rem <= shifted[31:0];
            quo <= {quo[30:0], 1'b0};
          end else begin
            rem <= diff[31:0];
            quo <= {quo[30:0], 1'b1};
          end
          cnt <= cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/stage_ex.sv
// rtl/stage_ex.sv - MIPS32 execute stage: ALU, HI/LO forwarding, multiplier and divider
module stage_ex
  import stage_ex_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input logic      clk,
  input logic      rst,
  stage_ex_if.slave bus
);

  logic [31:0] hi_fwd, lo_fwd;
  logic        is_div, is_sub, trap_add;
  logic [31:0] b_eff, sum;
  logic        ovf, slt_s, slt_u;
  logic signed [63:0] sa, sb, prod_s;
  logic [63:0] prod_u;
  logic [63:0] div_result;
  logic        div_ready;
  logic        unused_inst;

  assign unused_inst = &{1'b0, bus.inst[31:16]};

  always_comb begin
    if (bus.mem_whilo) begin
      hi_fwd = bus.mem_hi;
      lo_fwd = bus.mem_lo;
    end else if (bus.wb_whilo) begin
      hi_fwd = bus.wb_hi;
      lo_fwd = bus.wb_lo;
    end else begin
      hi_fwd = bus.hi_i;
      lo_fwd = bus.lo_i;
    end
  end

  // Subtraction reuses the adder as opv1 + ~opv2 + 1 so one overflow rule covers both.
  always_comb begin
    is_div   = (bus.aluop == EXE_DIV_OP) || (bus.aluop == EXE_DIVU_OP);
    is_sub   = (bus.aluop == EXE_SUB_OP) || (bus.aluop == EXE_SUBU_OP);
    b_eff    = is_sub ? ~bus.opv2 : bus.opv2;
    sum      = bus.opv1 + b_eff + {31'd0, is_sub};
    ovf      = (bus.opv1[31] == b_eff[31]) && (sum[31] != bus.opv1[31]);
    trap_add = ovf && ((bus.aluop == EXE_ADD_OP) || (bus.aluop == EXE_ADDI_OP) ||
                       (bus.aluop == EXE_SUB_OP));
    slt_s    = $signed(bus.opv1) < $signed(bus.opv2);
    slt_u    = bus.opv1 < bus.opv2;
    sa       = {{32{bus.opv1[31]}}, bus.opv1};
    sb       = {{32{bus.opv2[31]}}, bus.opv2};
    prod_s   = sa * sb;
    prod_u   = {32'd0, bus.opv1} * {32'd0, bus.opv2};
  end

  ex_div #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (is_div),
    .signed_div (bus.aluop == EXE_DIV_OP),
    .opa        (bus.opv1),
    .opb        (bus.opv2),
    .result     (div_result),
    .ready      (div_ready)
  );

  always_comb begin
    bus.we_o       = 1'b0;
    bus.waddr_o    = '0;
    bus.wdata_o    = '0;
    bus.whilo      = 1'b0;
    bus.hi_o       = '0;
    bus.lo_o       = '0;
    bus.aluop_o    = '0;
    bus.mem_addr   = '0;
    bus.store_data = '0;
    bus.stallreq   = 1'b0;
    if (!rst) begin
      bus.we_o       = bus.we_i & ~trap_add;
      bus.waddr_o    = bus.waddr_i;
      bus.aluop_o    = bus.aluop;
      bus.mem_addr   = bus.opv1 + {{16{bus.inst[15]}}, bus.inst[15:0]};
      bus.store_data = bus.opv2;
      bus.stallreq   = is_div & ~div_ready;

      case (bus.alusel)
        RES_LOGIC: case (bus.aluop)
          EXE_OR_OP:  bus.wdata_o = bus.opv1 | bus.opv2;
          EXE_AND_OP: bus.wdata_o = bus.opv1 & bus.opv2;
          EXE_XOR_OP: bus.wdata_o = bus.opv1 ^ bus.opv2;
          EXE_NOR_OP: bus.wdata_o = ~(bus.opv1 | bus.opv2);
          default:    bus.wdata_o = '0;
        endcase
        RES_SHIFT: case (bus.aluop)
          EXE_SLL_OP: bus.wdata_o = bus.opv2 << bus.opv1[4:0];
          EXE_SRL_OP: bus.wdata_o = bus.opv2 >> bus.opv1[4:0];
          EXE_SRA_OP: bus.wdata_o = 32'($signed(bus.opv2) >>> bus.opv1[4:0]);
          default:    bus.wdata_o = '0;
        endcase
        RES_MOVE: case (bus.aluop)
          EXE_MFHI_OP:              bus.wdata_o = hi_fwd;
          EXE_MFLO_OP:              bus.wdata_o = lo_fwd;
          EXE_MOVN_OP, EXE_MOVZ_OP: bus.wdata_o = bus.opv1;
          default:                  bus.wdata_o = '0;
        endcase
        RES_ARITH: case (bus.aluop)
          EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP,
          EXE_SUB_OP, EXE_SUBU_OP: bus.wdata_o = sum;
          EXE_SLT_OP:  bus.wdata_o = {31'd0, slt_s};
          EXE_SLTU_OP: bus.wdata_o = {31'd0, slt_u};
          EXE_CLZ_OP:  bus.wdata_o = {26'd0, count_lead(bus.opv1, 1'b0)};
          EXE_CLO_OP:  bus.wdata_o = {26'd0, count_lead(bus.opv1, 1'b1)};
          default:     bus.wdata_o = '0;
        endcase
        RES_MUL:         bus.wdata_o = prod_s[31:0];
        RES_JUMP_BRANCH: bus.wdata_o = bus.link_addr;
        default:         bus.wdata_o = '0;
      endcase

      case (bus.aluop)
        EXE_MULT_OP: begin
          bus.we_o = 1'b0;
          bus.whilo = 1'b1;
          {bus.hi_o, bus.lo_o} = prod_s;
        end
        EXE_MULTU_OP: begin
          bus.we_o = 1'b0;
          bus.whilo = 1'b1;
          {bus.hi_o, bus.lo_o} = prod_u;
        end
        EXE_MTHI_OP: begin
          bus.we_o  = 1'b0;
          bus.whilo = 1'b1;
          bus.hi_o  = bus.opv1;
          bus.lo_o  = lo_fwd;
        end
        EXE_MTLO_OP: begin
          bus.we_o  = 1'b0;
          bus.whilo = 1'b1;
          bus.hi_o  = hi_fwd;
          bus.lo_o  = bus.opv1;
        end
        EXE_DIV_OP, EXE_DIVU_OP: begin
          bus.we_o = 1'b0;
          if (div_ready) begin
            bus.whilo = 1'b1;
            {bus.hi_o, bus.lo_o} = div_result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_ex.sv
// tb/tb_stage_ex.sv - directed self-checking bench for stage_ex
module tb_stage_ex;
  import stage_ex_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n;

  always #5 clk = ~clk;

  stage_ex_if bus ();
  stage_ex dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [7:0] a, input logic [2:0] s, input logic [31:0] v1, input logic [31:0] v2);
    @(negedge clk);
    bus.aluop  = a;
    bus.alusel = s;
    bus.opv1   = v1;
    bus.opv2   = v2;
    #1;
  endtask

  // Issues a divide and counts stall cycles until End (bounded).
  task automatic run_div(input string tag, input logic [7:0] a, input logic [31:0] v1, input logic [31:0] v2,
                         input int exp_stall, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    op(a, RES_NOP, v1, v2);
    n = 0;
    while (bus.stallreq && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({tag, "_stall_cycles"}, 64'(n), 64'(exp_stall));
    check({tag, "_stallreq"}, 64'(bus.stallreq), 64'd0);
    check({tag, "_whilo"}, 64'(bus.whilo), 64'd1);
    check({tag, "_hi"}, 64'(bus.hi_o), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.lo_o), 64'(exp_lo));
    check({tag, "_we"}, 64'(bus.we_o), 64'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.aluop     = EXE_DIV_OP;
    bus.alusel    = RES_ARITH;
    bus.opv1      = 32'h0000_0100;
    bus.opv2      = 32'h0000_0003;
    bus.we_i      = 1'b1;
    bus.waddr_i   = 5'd3;
    bus.link_addr = 32'h0040_0008;
    bus.inst      = 32'h8C22_FFFC;
    bus.hi_i      = 32'hAAAA_0000;
    bus.lo_i      = 32'hBBBB_0000;
    bus.mem_whilo = 1'b0;
    bus.wb_whilo  = 1'b0;
    bus.mem_hi    = 32'h0;
    bus.mem_lo    = 32'h0;
    bus.wb_hi     = 32'h0;
    bus.wb_lo     = 32'h0;

    @(negedge clk);
    #1;
    check("rst_we", 64'(bus.we_o), 64'd0);
    check("rst_waddr", 64'(bus.waddr_o), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_stallreq", 64'(bus.stallreq), 64'd0);
    check("rst_whilo", 64'(bus.whilo), 64'd0);
    check("rst_aluop_o", 64'(bus.aluop_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.aluop = EXE_NOP_OP;

    op(EXE_ADD_OP, RES_ARITH, 32'h7FFF_FFFF, 32'h0000_0001);
    check("add_ovf_we", 64'(bus.we_o), 64'd0);
    op(EXE_ADDU_OP, RES_ARITH, 32'h7FFF_FFFF, 32'h0000_0001);
    check("addu_data", 64'(bus.wdata_o), 64'h8000_0000);
    check("addu_we", 64'(bus.we_o), 64'd1);
    check("addu_waddr", 64'(bus.waddr_o), 64'd3);
    op(EXE_SUB_OP, RES_ARITH, 32'h8000_0000, 32'h0000_0001);
    check("sub_ovf_we", 64'(bus.we_o), 64'd0);
    op(EXE_SUBU_OP, RES_ARITH, 32'h8000_0000, 32'h0000_0001);
    check("subu_data", 64'(bus.wdata_o), 64'h7FFF_FFFF);
    check("subu_we", 64'(bus.we_o), 64'd1);
    op(EXE_SLT_OP, RES_ARITH, 32'hFFFF_FFFF, 32'h0000_0001);
    check("slt", 64'(bus.wdata_o), 64'd1);
    op(EXE_SLTU_OP, RES_ARITH, 32'hFFFF_FFFF, 32'h0000_0001);
    check("sltu", 64'(bus.wdata_o), 64'd0);
    op(EXE_CLZ_OP, RES_ARITH, 32'h0000_0000, 32'h0);
    check("clz_zero", 64'(bus.wdata_o), 64'd32);
    op(EXE_CLZ_OP, RES_ARITH, 32'h0001_0000, 32'h0);
    check("clz_mid", 64'(bus.wdata_o), 64'd15);
    op(EXE_CLO_OP, RES_ARITH, 32'hFFFF_FFFF, 32'h0);
    check("clo_ones", 64'(bus.wdata_o), 64'd32);
    op(EXE_CLO_OP, RES_ARITH, 32'hF000_0000, 32'h0);
    check("clo_mid", 64'(bus.wdata_o), 64'd4);

    op(EXE_OR_OP, RES_LOGIC, 32'hF0F0_0000, 32'h0F0F_00FF);
    check("or", 64'(bus.wdata_o), 64'hFFFF_00FF);
    op(EXE_NOR_OP, RES_LOGIC, 32'h0, 32'h0);
    check("nor", 64'(bus.wdata_o), 64'hFFFF_FFFF);
    op(EXE_SRA_OP, RES_SHIFT, 32'd4, 32'h8000_0000);
    check("sra", 64'(bus.wdata_o), 64'hF800_0000);
    op(EXE_SRL_OP, RES_SHIFT, 32'd31, 32'h8000_0000);
    check("srl", 64'(bus.wdata_o), 64'h0000_0001);

    op(EXE_MUL_OP, RES_MUL, 32'hFFFF_FFFF, 32'd3);
    check("mul", 64'(bus.wdata_o), 64'hFFFF_FFFD);
    op(EXE_MULT_OP, RES_NOP, 32'hFFFF_FFFF, 32'd2);
    check("mult_whilo", 64'(bus.whilo), 64'd1);
    check("mult_hilo", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFFE);
    check("mult_we", 64'(bus.we_o), 64'd0);
    op(EXE_MULTU_OP, RES_NOP, 32'hFFFF_FFFF, 32'd2);
    check("multu_hilo", {bus.hi_o, bus.lo_o}, 64'h0000_0001_FFFF_FFFE);

    bus.mem_whilo = 1'b1;
    bus.mem_hi    = 32'h0000_1234;
    bus.wb_whilo  = 1'b1;
    bus.wb_hi     = 32'h0000_5678;
    bus.wb_lo     = 32'h0000_BEEF;
    op(EXE_MFHI_OP, RES_MOVE, 32'h0, 32'h0);
    check("mfhi_mem", 64'(bus.wdata_o), 64'h0000_1234);
    bus.mem_whilo = 1'b0;
    op(EXE_MFHI_OP, RES_MOVE, 32'h0, 32'h0);
    check("mfhi_wb", 64'(bus.wdata_o), 64'h0000_5678);
    op(EXE_MTHI_OP, RES_MOVE, 32'hCAFE_0001, 32'h0);
    check("mthi_whilo", 64'(bus.whilo), 64'd1);
    check("mthi_hilo", {bus.hi_o, bus.lo_o}, 64'hCAFE_0001_0000_BEEF);
    check("mthi_we", 64'(bus.we_o), 64'd0);
    bus.wb_whilo = 1'b0;
    op(EXE_MFHI_OP, RES_MOVE, 32'h0, 32'h0);
    check("mfhi_arch", 64'(bus.wdata_o), 64'hAAAA_0000);

    op(EXE_JAL_OP, RES_JUMP_BRANCH, 32'h0, 32'h0);
    check("jal_link", 64'(bus.wdata_o), 64'h0040_0008);
    op(EXE_LW_OP, RES_LOAD_STORE, 32'h0000_1000, 32'hDEAD_BEEF);
    check("lw_addr", 64'(bus.mem_addr), 64'h0000_0FFC);
    check("lw_store_data", 64'(bus.store_data), 64'hDEAD_BEEF);
    check("lw_wdata", 64'(bus.wdata_o), 64'd0);
    check("lw_aluop_o", 64'(bus.aluop_o), 64'(EXE_LW_OP));

    run_div("div_neg", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_div("div_b2b", EXE_DIV_OP, 32'd100, 32'hFFFF_FFF9, 33, 32'h0000_0002, 32'hFFFF_FFF2);
    run_div("divu_zero", EXE_DIVU_OP, 32'h0000_0010, 32'd0, 2, 32'd0, 32'd0);

    op(EXE_DIV_OP, RES_NOP, 32'h0000_0100, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    bus.aluop = EXE_NOP_OP;
    #1;
    check("rstmid_whilo", 64'(bus.whilo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_stallreq", 64'(bus.stallreq), 64'd0);
    check("rstmid_whilo_after", 64'(bus.whilo), 64'd0);
    run_div("divu_after_rst", EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd2, 32'd14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_ex.md
Name: stage_ex

Overview:
- Execute stage of the 5-stage MIPS32 pipeline. It consumes decoded operands from the ID/EX register and produces GPR writeback data, HI/LO updates and memory address/data for the MEM stage.
- All ALU functions are combinational except DIV/DIVU. Those use an embedded 32-cycle radix-2 divider that stalls the pipeline through stallreq.

Parameters:
- DIV_CYCLES, 32, iterations of the divider's On state (fixed to operand width; not for tuning)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- aluop  in  8  operation code from ID/EX
- alusel  in  3  result class (NOP/LOGIC/SHIFT/MOVE/ARITH/MUL/JUMP_BRANCH/LOAD_STORE)
- opv1, opv2  in  32 each  operand values, already forwarded
- we_i  in  1  GPR write enable from ID
- waddr_i  in  5  GPR destination
- link_addr  in  32  return address for JAL/JALR/BxxAL
- inst  in  32  instruction word (offset for load/store)
- hi_i, lo_i  in  32 each  architectural HI/LO
- mem_whilo, wb_whilo  in  1 each  HI/LO write pending in MEM, WB
- mem_hi, mem_lo, wb_hi, wb_lo  in  32 each  pending HI/LO values
- we_o  out  1  GPR write enable to MEM
- waddr_o  out  5  GPR destination to MEM
- wdata_o  out  32  GPR write data
- whilo  out  1  HI/LO write enable
- hi_o, lo_o  out  32 each  HI/LO write values
- aluop_o  out  8  aluop pass-through (MEM uses it; ID uses it for load-use detection)
- mem_addr  out  32  effective address = opv1 + sext(inst[15:0])
- store_data  out  32  opv2 pass-through
- stallreq  out  1  hold IF/ID/EX while divider busy

Behaviour:
- While rst=1: every output is 0 and the divider state is forced to Free with counter 0.
- Latency for all ops except DIV/DIVU: 0 cycles (combinational from inputs).
- HI/LO forwarding priority: mem_* (if mem_whilo) > wb_* (if wb_whilo) > hi_i/lo_i.
- LOGIC: OR, AND, XOR, NOR.
- SHIFT: SLL, SRL, SRA by opv1[4:0] of opv2.
- ARITH results:
  - ADD/ADDI/ADDU/ADDIU/SUB/SUBU: 32-bit wrap.
  - SLT: signed compare. SLTU: unsigned compare. Result is 1 or 0.
  - CLZ/CLO on opv1; all-zero (CLZ) or all-one (CLO) input gives 32.
- Overflow: ADD/ADDI/SUB with signed overflow force we_o=0, with no exception. The U variants never suppress the write.
- MUL: wdata_o = low 32 bits of the signed product.
- MULT/MULTU: whilo=1, {hi_o, lo_o} = 64-bit product; we_o=0.
- MOVE ops:
  - MFHI/MFLO: wdata_o = forwarded HI/LO.
  - MOVN/MOVZ: wdata_o = opv1.
  - MTHI: whilo=1, hi_o=opv1, lo_o=forwarded LO.
  - MTLO: symmetric to MTHI.
- JUMP_BRANCH: wdata_o = link_addr.
- LOAD_STORE: wdata_o=0. mem_addr and store_data are valid for all loads and stores.
- we_o/waddr_o otherwise follow we_i/waddr_i. we_o is 0 for DIV/DIVU/MULT/MULTU/MTHI/MTLO.
- Divider FSM (states Free, ByZero, On, End):
  - Free: if DIV/DIVU is present and opv2==0, go to ByZero; else if DIV/DIVU is present, go to On with counter=0, latching operands (absolute values for DIV). Otherwise stay in Free.
  - ByZero: go to End with quotient=remainder=0.
  - On: one restoring shift-subtract step per cycle. After DIV_CYCLES steps, go to End.
  - End: div_ready=1 for exactly one cycle. Next state is always Free.
- Divider outputs: in End, whilo=1, lo_o=quotient, hi_o=remainder.
- Signed DIV fix-up: quotient is negated if operand signs differ. Remainder takes the sign of the dividend.
- stallreq=1 whenever a DIV/DIVU is present and the FSM is not in End:
  - Normal division: EX residency is 34 cycles, with stallreq high for the first 33.
  - Divide by zero: EX residency is 3 cycles, with stallreq high for the first 2.
- Upstream holds aluop/opv1/opv2 stable while stallreq=1.
- Back-to-back DIVs: End→Free, then the following DIV starts in the next cycle with no lost state.
- rst mid-division: abort immediately; no HI/LO write issued.

Decomposition:
- aluop/alusel codes and EXE_* constants stay in the shared consts.v header. Add the divider state encodings (DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END) there.
- One sub-module, ex_div:
  - Inputs: clk, rst, start, signed_div, opa, opb.
  - Outputs: result[63:0] as {remainder, quotient}, ready.
  - Owns the FSM and counter. stage_ex instantiates it and derives stallreq.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, we_i=1 → we_o=0. ADDU with the same operands → wdata_o=0x80000000, we_o=1.
- DIV -7 / 2 → stallreq high for 33 cycles. Cycle 34: whilo=1, lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF, stallreq=0.
- DIVU 0x10 / 0 → stallreq high for 2 cycles, then whilo=1, hi_o=lo_o=0.
- MFHI with mem_whilo=1/mem_hi=0x1234 and wb_whilo=1/wb_hi=0x5678 → wdata_o=0x1234. With mem_whilo=0 → 0x5678.
- MULT 0xFFFFFFFF × 2 → hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE. MULTU with the same operands → hi_o=0x00000001, lo_o=0xFFFFFFFE.
- rst pulsed at cycle 10 of a DIV → next cycle stallreq=0, whilo=0. A DIVU 100/7 issued afterward completes in the full 34 cycles with lo_o=14, hi_o=2.
